// File: rtl/pipe_pkg.sv
// Shared execute/memory pipeline types and defaults.
// Holds the ctrl bundle layout and payload width defaults.
package pipe_pkg;

  localparam int DATAW_DEF = 32;
  localparam int REGW_DEF  = 3;

  typedef struct packed {
    logic                fft_wr_en;
    logic                reg_wr_en;
    logic                p_flag;
    logic [REGW_DEF-1:0] wr_reg;
  } ex_mem_ctrl_t;

  localparam int CTRLW_DEF = $bits(ex_mem_ctrl_t);

  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: main + skid register, registered ready.
// Ports: clk/rst_n/flush, in_* upstream side, out_* downstream side.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int CTRLW = CTRLW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [DATAW-1:0] out_data
);

  logic             r_live;
  logic             r_main_v;
  logic [CTRLW-1:0] r_main_ctrl;
  logic [DATAW-1:0] r_main_data;
  logic             r_skid_v;
  logic [CTRLW-1:0] r_skid_ctrl;
  logic [DATAW-1:0] r_skid_data;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_free;

  // r_live keeps ready low until the first edge after reset.
  assign in_ready    = r_live & ~r_skid_v & ~flush;
  assign out_valid   = r_main_v;
  assign out_ctrl    = r_main_ctrl;
  assign out_data    = r_main_data;

  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = r_main_v & out_ready;
  assign w_main_free = ~r_main_v | w_out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_main_v    <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_v    <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_main_v    <= 1'b0;
        r_main_ctrl <= '0;
        r_main_data <= '0;
        r_skid_v    <= 1'b0;
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
      end else if (w_main_free) begin
        // skid full implies in_ready low, so no
        // accept can collide with the refill.
        if (r_skid_v) begin
          r_main_v    <= 1'b1;
          r_main_ctrl <= r_skid_ctrl;
          r_main_data <= r_skid_data;
          r_skid_v    <= 1'b0;
        end else begin
          r_main_v <= w_in_fire;
          if (w_in_fire) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end
        end
      end else if (w_in_fire) begin
        r_skid_v    <= 1'b1;
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Chain of DEPTH skid stages with occupancy count and zeroed idle output.
// Ports: clk/rst_n/flush, in_* upstream, out_* downstream, occupancy.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int CTRLW = CTRLW_DEF,
  parameter int DEPTH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRLW-1:0]          in_ctrl,
  input  logic [DATAW-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRLW-1:0]          out_ctrl,
  output logic [DATAW-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int OCCW = occ_w(DEPTH);

  logic             w_v [DEPTH+1];
  logic             w_r [DEPTH+1];
  logic [CTRLW-1:0] w_c [DEPTH+1];
  logic [DATAW-1:0] w_d [DEPTH+1];

  logic             w_in_fire;
  logic             w_out_fire;
  logic [OCCW-1:0]  r_occ;

  assign w_v[0]     = in_valid;
  assign w_c[0]     = in_ctrl;
  assign w_d[0]     = in_data;
  assign in_ready   = w_r[0];
  assign w_r[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    skid_stage #(
      .DATAW (DATAW),
      .CTRLW (CTRLW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (w_v[i]),
      .in_ready  (w_r[i]),
      .in_ctrl   (w_c[i]),
      .in_data   (w_d[i]),
      .out_valid (w_v[i+1]),
      .out_ready (w_r[i+1]),
      .out_ctrl  (w_c[i+1]),
      .out_data  (w_d[i+1])
    );
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_v[DEPTH] & out_ready;

  assign out_valid  = w_v[DEPTH];
  assign out_ctrl   = w_v[DEPTH] ? w_c[DEPTH] : '0;
  assign out_data   = w_v[DEPTH] ? w_d[DEPTH] : '0;
  assign occupancy  = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCCW'(w_in_fire)
                     - OCCW'(w_out_fire);
    end
  end

endmodule
